// File: rtl/sdram_aref_burst.sv
// sdram_aref_burst: periodic SDRAM auto-refresh engine with pending debt and burst servicing
module sdram_aref_burst #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int DQM_W     = 4,
    parameter int BA_W      = 2,
    parameter int TREF_CYC  = 2048,
    parameter int TRP_CYC   = 2,
    parameter int TRFC_CYC  = 10,
    parameter int MAX_PEND  = 8,
    parameter int URGENT_TH = 4,
    parameter int MAX_BURST = 4,
    localparam int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic              init_end,
    output logic              aref_req,
    output logic              aref_urgent,
    input  logic              aref_en,
    output logic              aref_done,
    output logic [PW-1:0]     aref_pend,
    output logic              aref_overflow,
    output logic              aref_cs_n,
    output logic              aref_ras_n,
    output logic              aref_cas_n,
    output logic              aref_we_n,
    output logic [ADDR_W-1:0] aref_addr,
    output logic [BA_W-1:0]   aref_ba,
    output logic [DATA_W-1:0] aref_data,
    output logic              aref_oe_n,
    output logic [DQM_W-1:0]  aref_dqm
);

    localparam int IW   = (TREF_CYC > 2) ? $clog2(TREF_CYC) : 1;
    localparam int MAXW = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int WW   = $clog2(MAXW + 1);
    localparam int BW   = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRFC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_init;
    logic [IW-1:0]   r_icnt;
    logic            r_tick;
    logic [PW-1:0]   r_pend;
    logic            r_ovf;
    logic [BW-1:0]   r_burst;
    logic [WW-1:0]   r_wait;
    logic            w_issue;
    logic            w_req;
    logic            w_wrap;
    logic [3:0]      w_cmd;

    assign w_issue = (r_state == S_AREF);
    assign w_req   = (r_pend != '0) && (r_state == S_IDLE);
    assign w_wrap  = (r_icnt == IW'(TREF_CYC - 1));

    // Init-done latch: once set, stays set until reset
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n)
            r_init <= 1'b0;
        else if (init_end)
            r_init <= 1'b1;
    end

    // Free-running refresh interval; a registered tick fires once per wrap
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_icnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= r_init && w_wrap;
            if (r_init)
                r_icnt <= w_wrap ? '0 : r_icnt + 1'b1;
        end
    end

    // Refresh debt: ticks add, issued AREFs subtract, saturating with sticky overflow
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else if (r_tick && !w_issue) begin
            if (r_pend == PW'(MAX_PEND))
                r_ovf <= 1'b1;
            else
                r_pend <= r_pend + 1'b1;
        end else if (w_issue && !r_tick) begin
            r_pend <= r_pend - 1'b1;
        end
    end

    // State register
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Spacing counter restarts on every state change and runs only in wait states
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n)
            r_wait <= '0;
        else if (r_state != w_next)
            r_wait <= '0;
        else if (r_state == S_TRP || r_state == S_TRFC)
            r_wait <= r_wait + 1'b1;
    end

    // AREF commands issued in the current sequence
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n)
            r_burst <= '0;
        else if (r_state == S_DONE)
            r_burst <= '0;
        else if (w_issue)
            r_burst <= r_burst + 1'b1;
    end

    // Next-state logic: PRE, tRP wait, then AREF/tRFC pairs until burst limit or debt cleared
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = (w_req && aref_en) ? S_PRE : S_IDLE;
            S_PRE:  w_next = S_TRP;
            S_TRP:  w_next = (r_wait == WW'(TRP_CYC - 1)) ? S_AREF : S_TRP;
            S_AREF: w_next = S_TRFC;
            S_TRFC: w_next = (r_wait != WW'(TRFC_CYC - 1)) ? S_TRFC :
                             (r_burst < BW'(MAX_BURST) && r_pend != '0) ? S_AREF : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command decode straight from state: PRE=0010, AREF=0001, otherwise NOP
    always_comb begin
        w_cmd = (r_state == S_PRE)  ? 4'b0010 :
                (r_state == S_AREF) ? 4'b0001 : 4'b0111;
    end

    assign {aref_cs_n, aref_ras_n, aref_cas_n, aref_we_n} = w_cmd;
    assign aref_req      = w_req;
    assign aref_urgent   = (r_pend >= PW'(URGENT_TH));
    assign aref_done     = (r_state == S_DONE);
    assign aref_pend     = r_pend;
    assign aref_overflow = r_ovf;
    assign aref_addr     = ADDR_W'(11'h400);
    assign aref_ba       = '0;
    assign aref_data     = '0;
    assign aref_oe_n     = 1'b1;
    assign aref_dqm      = '0;

endmodule

// File: tb/tb_sdram_aref_burst.sv
// tb_sdram_aref_burst: directed checks of refresh timing, debt, burst and reset behaviour
module tb_sdram_aref_burst;

    logic        sclk = 1'b0;
    logic        srst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;

    logic        req_a, urg_a, done_a, ovf_a, oe_a;
    logic [3:0]  pend_a, cmd_a, dqm_a;
    logic [10:0] addr_a;
    logic [1:0]  ba_a;
    logic [31:0] data_a;

    logic        req_b, urg_b, done_b, ovf_b, oe_b;
    logic [3:0]  pend_b, cmd_b, dqm_b;
    logic [10:0] addr_b;
    logic [1:0]  ba_b;
    logic [31:0] data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bad;

    always #5 sclk = ~sclk;

    sdram_aref_burst #(.TREF_CYC(16)) u_a (
        .sclk(sclk), .srst_n(srst_n), .init_end(init_end),
        .aref_req(req_a), .aref_urgent(urg_a), .aref_en(en_a), .aref_done(done_a),
        .aref_pend(pend_a), .aref_overflow(ovf_a),
        .aref_cs_n(cmd_a[3]), .aref_ras_n(cmd_a[2]), .aref_cas_n(cmd_a[1]), .aref_we_n(cmd_a[0]),
        .aref_addr(addr_a), .aref_ba(ba_a), .aref_data(data_a), .aref_oe_n(oe_a), .aref_dqm(dqm_a)
    );

    sdram_aref_burst #(.TREF_CYC(200)) u_b (
        .sclk(sclk), .srst_n(srst_n), .init_end(init_end),
        .aref_req(req_b), .aref_urgent(urg_b), .aref_en(en_b), .aref_done(done_b),
        .aref_pend(pend_b), .aref_overflow(ovf_b),
        .aref_cs_n(cmd_b[3]), .aref_ras_n(cmd_b[2]), .aref_cas_n(cmd_b[1]), .aref_we_n(cmd_b[0]),
        .aref_addr(addr_b), .aref_ba(ba_b), .aref_data(data_b), .aref_oe_n(oe_b), .aref_dqm(dqm_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        step();
        step();
        chk("rst_req", {31'b0, req_b}, 0);
        chk("rst_urg", {31'b0, urg_b}, 0);
        chk("rst_done", {31'b0, done_b}, 0);
        chk("rst_pend", {28'b0, pend_b}, 0);
        chk("rst_cmd", {28'b0, cmd_b}, 32'h7);
        chk("rst_const", {oe_b, dqm_b, ba_b, data_b[15:0], addr_b}, {1'b1, 4'h0, 2'b0, 16'h0, 11'h400});
        srst_n = 1'b1;
        step();
        init_end = 1'b1;
        step();
        cyc = 0;
        init_end = 1'b0;
        bad = 0;
        while (cyc < 16) begin
            step();
            if (cmd_a !== 4'b0111 || pend_a !== 4'd0) bad++;
        end
        chk("t1_nop_before_tick", bad, 0);
        step();
        chk("t1_pend", {28'b0, pend_a}, 1);
        chk("t1_req", {31'b0, req_a}, 1);
        chk("t1_cmd_nop", {28'b0, cmd_a}, 32'h7);
        wait_to(28);
        en_a = 1'b1;
        step();
        en_a = 1'b0;
        chk("t5_pre", {28'b0, cmd_a}, 32'h2);
        chk("t5_a10", {21'b0, addr_a}, 32'h400);
        wait_to(32);
        chk("t5_aref", {28'b0, cmd_a}, 32'h1);
        chk("t5_pend_before", {28'b0, pend_a}, 1);
        step();
        chk("t5_pend_tick_aref", {28'b0, pend_a}, 1);
        chk("t5_trfc_nop", {28'b0, cmd_a}, 32'h7);
        wait_to(43);
        chk("t5_burst_cont", {28'b0, cmd_a}, 32'h1);
        chk("t2_b_idle_pend", {28'b0, pend_b}, 0);
        wait_to(201);
        chk("t2_pend", {28'b0, pend_b}, 1);
        chk("t2_req", {31'b0, req_b}, 1);
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        chk("t2_pre", {28'b0, cmd_b}, 32'h2);
        chk("t2_req_off", {31'b0, req_b}, 0);
        wait_to(204);
        chk("t2_trp_nop", {28'b0, cmd_b}, 32'h7);
        step();
        chk("t2_aref", {28'b0, cmd_b}, 32'h1);
        step();
        chk("t2_pend_dec", {28'b0, pend_b}, 0);
        wait_to(215);
        chk("t2_done_early", {31'b0, done_b}, 0);
        step();
        chk("t2_done", {31'b0, done_b}, 1);
        chk("t2_done_cmd", {28'b0, cmd_b}, 32'h7);
        step();
        chk("t2_done_pulse", {31'b0, done_b}, 0);
        chk("t2_req_end", {31'b0, req_b}, 0);
        wait_to(1000);
        chk("t3_pend3", {28'b0, pend_b}, 3);
        chk("t3_urg_low", {31'b0, urg_b}, 0);
        step();
        chk("t3_pend4", {28'b0, pend_b}, 4);
        chk("t3_urg_high", {31'b0, urg_b}, 1);
        wait_to(1201);
        chk("t3_pend5", {28'b0, pend_b}, 5);
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        chk("t3_pre", {28'b0, cmd_b}, 32'h2);
        for (int k = 0; k < 4; k++) begin
            wait_to(1205 + 11 * k);
            chk($sformatf("t3_aref%0d", k), {28'b0, cmd_b}, 32'h1);
            step();
            chk($sformatf("t3_pend_after%0d", k), {28'b0, pend_b}, 32'(4 - k));
        end
        wait_to(1248);
        chk("t3_last_trfc", {28'b0, cmd_b}, 32'h7);
        step();
        chk("t3_done", {31'b0, done_b}, 1);
        step();
        chk("t3_pend_left", {28'b0, pend_b}, 1);
        chk("t3_req_again", {31'b0, req_b}, 1);
        wait_to(2800);
        chk("t4_pend_sat", {28'b0, pend_b}, 8);
        chk("t4_ovf_low", {31'b0, ovf_b}, 0);
        step();
        chk("t4_pend_hold", {28'b0, pend_b}, 8);
        chk("t4_ovf_set", {31'b0, ovf_b}, 1);
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        wait_to(2849);
        chk("t4_done", {31'b0, done_b}, 1);
        step();
        chk("t4_pend_after", {28'b0, pend_b}, 4);
        chk("t4_ovf_sticky", {31'b0, ovf_b}, 1);
        chk("t4_urg", {31'b0, urg_b}, 1);
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        wait_to(2854);
        chk("t6_aref", {28'b0, cmd_b}, 32'h1);
        wait_to(2858);
        chk("t6_in_trfc", {28'b0, cmd_b}, 32'h7);
        #2;
        srst_n = 1'b0;
        #1;
        chk("t6_pend", {28'b0, pend_b}, 0);
        chk("t6_ovf", {31'b0, ovf_b}, 0);
        chk("t6_urg", {31'b0, urg_b}, 0);
        chk("t6_req", {31'b0, req_b}, 0);
        chk("t6_done", {31'b0, done_b}, 0);
        chk("t6_cmd", {28'b0, cmd_b}, 32'h7);
        step();
        srst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (pend_b !== 4'd0 || req_b !== 1'b0 || cmd_b !== 4'b0111 || pend_a !== 4'd0) bad++;
        end
        chk("t6_no_refresh", bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
